// File: rtl/fifo_nibble_tx_if.sv
// rtl/fifo_nibble_tx_if.sv - FIFO read-side bundle between a FIFO and the nibble transmitter
interface fifo_nibble_tx_if #(
  parameter int DATA_W = 4
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_nibble_tx.sv
// rtl/fifo_nibble_tx.sv - pops FIFO words and sends each as a serial frame
// Frame: start(0), DATA_W bits LSB first, optional even parity, stop(1); all outputs registered.
module fifo_nibble_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  fifo_nibble_tx_if.master fifo,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic              ONE_CLK   = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic              tx_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_end;

  assign baud_end        = (baud_q == BAUD_LAST);
  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

  // rst_n is active-high to match the FIFO this block sits next to.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (ena && !fifo.fifo_empty) begin
            state_q <= ST_POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_POP: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_q  <= fifo.fifo_rd_data;
          parity_q <= ^fifo.fifo_rd_data;
          baud_q   <= '0;
          bit_q    <= '0;
          tx_q     <= 1'b0;
          state_q  <= ST_START;
        end
        ST_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                done_q  <= ONE_CLK;
                state_q <= ST_STOP;
              end
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= ONE_CLK;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          // frame_done is registered, so it is raised one cycle ahead of the last stop cycle.
          if (baud_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
            done_q <= (baud_q == BAUD_PRE);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// tb/tb_fifo_nibble_tx.sv - scoreboard bench for fifo_nibble_tx
module tb_fifo_nibble_tx;

  localparam int CPB    = 4;
  localparam int FRAME  = (4 + 1 + 2) * CPB;
  localparam int FRAME2 = (4 + 0 + 2) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic ena   = 1'b0;
  logic tx, busy, frame_done;
  logic tx2, busy2, frame_done2;

  fifo_nibble_tx_if #(.DATA_W(4)) fif ();
  fifo_nibble_tx_if #(.DATA_W(4)) fif2 ();

  fifo_nibble_tx #(.CLKS_PER_BIT(CPB), .DATA_W(4), .PARITY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .fifo(fif),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_nibble_tx #(.CLKS_PER_BIT(CPB), .DATA_W(4), .PARITY_EN(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .fifo(fif2),
    .tx(tx2), .busy(busy2), .frame_done(frame_done2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected tx waveform, one bit per clock, built from the frame's slot list.
  function automatic logic [63:0] frame_of(input logic [3:0] w, input bit pe);
    logic [63:0] v;
    int slots[$];
    v = '1;
    slots.push_back(0);
    for (int i = 0; i < 4; i++) slots.push_back(int'(w[i]));
    if (pe) slots.push_back($countones(w) % 2);
    slots.push_back(1);
    for (int s = 0; s < slots.size(); s++)
      for (int k = 0; k < CPB; k++) v[s*CPB + k] = (slots[s] != 0);
    return v;
  endfunction

  logic [3:0]  fifo_q[$];
  logic [63:0] exp_q[$];
  int          cycle_no    = 0;
  logic        rst_at_edge = 1'b0;
  bit          mon_on      = 1'b0;

  always @(posedge clk) begin
    cycle_no    <= cycle_no + 1;
    rst_at_edge <= rst_n;
    if (rst_n) mon_on <= 1'b1;
    if (fif.fifo_rd_en === 1'b1 && fifo_q.size() > 0) fif.fifo_rd_data <= fifo_q.pop_front();
    fif.fifo_empty <= (fifo_q.size() == 0);
  end

  bit          active    = 1'b0;
  int          cyc       = 0;
  logic [63:0] cur       = '1;
  int          pop_count = 0;
  int          fd_count  = 0;
  int          pop_times[$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_at_edge) begin
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fif.fifo_rd_en, 0);
        chk("rst_done", frame_done, 0);
        active = 1'b0;
      end else begin
        if (frame_done === 1'b1) fd_count++;
        if (active) begin
          cyc++;
          chk("rd_en_single", fif.fifo_rd_en, 0);
          if (cyc == 1) begin
            chk("load_tx", tx, 1);
            chk("load_busy", busy, 1);
            chk("load_done", frame_done, 0);
          end else if (cyc <= FRAME + 1) begin
            chk($sformatf("frame_tx@%0d", cyc), tx, cur[cyc-2]);
            chk($sformatf("frame_busy@%0d", cyc), busy, 1);
            chk($sformatf("frame_done@%0d", cyc), frame_done, (cyc == FRAME + 1));
          end else begin
            chk("post_busy", busy, 0);
            chk("post_tx", tx, 1);
            chk("post_done", frame_done, 0);
            active = 1'b0;
          end
        end else if (fif.fifo_rd_en === 1'b1) begin
          chk("pop_pending", (exp_q.size() > 0), 1);
          chk("pop_busy", busy, 1);
          chk("pop_tx", tx, 1);
          if (exp_q.size() > 0) begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            cyc    = 0;
            pop_count++;
            pop_times.push_back(cycle_no);
          end
        end else begin
          chk("idle_tx", tx, 1);
          chk("idle_busy", busy, 0);
          chk("idle_done", frame_done, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(frame_of(w, 1'b1));
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int n = 0;
    while (pop_count < target && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_pop_timeout"}, (pop_count >= target), 1);
  endtask

  task automatic drain(input string name, input int budget, input bit rnd_ena);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || active) && n < budget) begin
      if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    ena = 1'b1;
    chk({name, "_drain_timeout"}, (n < budget), 1);
  endtask

  initial begin
    int p0, fd0, n;
    logic [63:0] e2;

    fif2.fifo_empty   = 1'b1;
    fif2.fifo_rd_data = 4'h0;

    // reset held two cycles, then idle with an empty FIFO
    tick();
    tick();
    rst_n = 1'b0;
    repeat (5) tick();

    // enable low blocks the pop; then the single-word frame
    push(4'b1010);
    repeat (10) tick();
    chk("ena_low_no_pop", pop_count, 0);
    ena = 1'b1;
    drain("single", 80, 1'b0);

    push(4'b1011);
    drain("odd_parity", 80, 1'b0);

    // back-to-back pops are one frame plus three cycles apart
    push(4'b1010);
    push(4'b1100);
    drain("b2b", 120, 1'b0);
    chk("b2b_spacing", pop_times[pop_times.size()-1] - pop_times[pop_times.size()-2], FRAME + 3);

    // enable dropped during START: frame completes, next pop waits
    p0  = pop_count;
    fd0 = fd_count;
    push(4'b0101);
    push(4'b0011);
    wait_pops("ena_drop", p0 + 1, 60);
    repeat (3) tick();
    ena = 1'b0;
    repeat (45) tick();
    chk("ena_drop_pops", pop_count, p0 + 1);
    chk("ena_drop_done", fd_count, fd0 + 1);
    ena = 1'b1;
    drain("ena_drop", 120, 1'b0);

    // reset during the second data bit discards the frame
    p0 = pop_count;
    push(4'b0110);
    wait_pops("mid_rst", p0 + 1, 60);
    fd0 = fd_count;
    repeat (9) tick();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    repeat (10) tick();
    chk("mid_rst_no_done", fd_count, fd0);
    chk("mid_rst_no_pop", pop_count, p0 + 1);
    push(4'b1001);
    drain("after_rst", 80, 1'b0);

    // parity disabled: 24-cycle frame with no parity slot
    fif2.fifo_empty = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fif2.fifo_rd_en !== 1'b1 && n < 20);
    chk("np_pop", fif2.fifo_rd_en, 1);
    fif2.fifo_empty   = 1'b1;
    fif2.fifo_rd_data = 4'b1011;
    e2 = frame_of(4'b1011, 1'b0);
    for (int c = 1; c <= FRAME2 + 2; c++) begin
      @(negedge clk);
      chk("np_rd_en_once", fif2.fifo_rd_en, 0);
      if (c >= 2 && c <= FRAME2 + 1) chk($sformatf("np_tx@%0d", c), tx2, e2[c-2]);
      chk($sformatf("np_done@%0d", c), frame_done2, (c == FRAME2 + 1));
      if (c == FRAME2 + 2) chk("np_busy_end", busy2, 0);
    end
    tick();

    // randomized words with ena toggling at random
    for (int i = 0; i < 10; i++) push(4'($urandom_range(0, 15)));
    drain("random", 2000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_tx.md
FIFO_NIBBLE_TX -- requirements
Module: fifo_nibble_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning the width of the FIFO word and of each frame's data field.
REQ-003 The block SHALL have parameter PARITY_EN, default 1, where 1 adds an even-parity bit and 0 omits it.
REQ-004 clk  input  1  sole clock; all state changes occur on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-high despite the name, matching the codebase FIFO's reset port.
REQ-006 ena  input  1  enable; when low, no new FIFO pop is started.
REQ-007 fifo_empty  input  1  FIFO empty flag from the FIFO read side.
REQ-008 fifo_rd_data  input  DATA_W  FIFO read data, valid the cycle after fifo_rd_en is high.
REQ-009 fifo_rd_en  output  1  FIFO read strobe, high for exactly one cycle per pop.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  high from the POP state through the last STOP cycle.
REQ-012 frame_done  output  1  one-cycle pulse on the last cycle of STOP.

Function
REQ-013 The FSM SHALL have states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE: tx=1; if ena=1 and fifo_empty=0 then next state is POP, else the FSM stays in IDLE.
REQ-015 POP: fifo_rd_en=1 for this single cycle only; next state is LOAD unconditionally, even if fifo_empty or ena changes.
REQ-016 LOAD: fifo_rd_data SHALL be captured into the shift register and parity computed as the XOR of all data bits; next state is START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles; tx goes low in the cycle 2 cycles after fifo_rd_en was high.
REQ-018 DATA: DATA_W bits SHALL be sent LSB first, CLKS_PER_BIT cycles each; a bit counter and a baud counter sized to their parameters control timing.
REQ-019 PARITY: entered only if PARITY_EN=1; tx=parity bit for CLKS_PER_BIT cycles.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, with frame_done=1 on the final cycle; next state is IDLE.
REQ-021 Frame length SHALL be (DATA_W+PARITY_EN+2)*CLKS_PER_BIT cycles: 28 with defaults.
REQ-022 Back-to-back pops SHALL be spaced (frame length + 3) cycles: 31 with defaults, comprising POP, LOAD, the frame, and one IDLE cycle.
REQ-023 ena deasserted mid-frame SHALL NOT abort the frame; it only blocks the next POP.
REQ-024 fifo_empty SHALL be sampled only in IDLE; the block never asserts fifo_rd_en while fifo_empty=1 is sampled in IDLE.
REQ-025 Counters SHALL wrap to zero at each bit boundary, with no cumulative drift across frames.

Reset
REQ-026 With rst_n=1 at a clock edge, the next cycle SHALL show state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, and all counters and the shift register cleared.
REQ-027 Reset mid-frame SHALL abort the frame immediately: no frame_done, no partial-bit extension, and the popped word is discarded.
REQ-028 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-029 Reset: rst_n=1 for 2 cycles, then 0 -> tx=1, fifo_rd_en=0, busy=0, frame_done=0; the outputs stay in that state while fifo_empty=1.
REQ-030 Single word: fifo_empty=0 for 1 cycle, fifo_rd_data=4'b1010 -> one fifo_rd_en pulse; tx sequence 0,0,1,0,1,0(parity),1, each held 4 cycles; frame_done on cycle 28 of the frame; busy drops the following cycle.
REQ-031 Odd parity: fifo_rd_data=4'b1011 -> data bits 1,1,0,1, then parity bit 1; with PARITY_EN=0 the frame is 24 cycles with no parity slot.
REQ-032 Back-to-back: fifo_rd_data=4'b1010 then 4'b1100 with fifo_empty=0 throughout -> exactly two fifo_rd_en pulses 31 cycles apart; second data field is 0,0,1,1 with parity 0.
REQ-033 Mid-frame reset: rst_n=1 during the 2nd DATA bit -> tx=1 the next cycle, no frame_done, and no fifo_rd_en until reset is released and fifo_empty=0 with ena=1.
REQ-034 Enable gating: ena=0 with fifo_empty=0 -> no fifo_rd_en; ena dropped during START -> the full 28-cycle frame completes, then the block idles.
